// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, ALUOp
// codes, datapath select codes and the controller state encoding.
package mips_ctrl_pkg;

  // Opcode field IR[31:26]
  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] J      = 6'h02;

  // ALU operation codes; ALU_RTYPE defers to the funct field
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_AND   = 3'b110;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BR_EQ    = 4'd11,
    S_BR_NE    = 4'd12,
    S_JUMP     = 4'd13
  } state_t;

  // True for every opcode the controller can sequence
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      R_TYPE, ADDI, ORI, ANDI, LW, SW, BEQ, BNE, J: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  // ALU operation for the immediate arithmetic/logic group
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      ORI:     return ALU_OR;
      ANDI:    return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the shared memory port and flags the cycle
// in which the wait budget runs out. MEM_TIMEOUT = 0 disables the flag.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TMO_W       = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  // Last count value at which a still-pending access is abandoned: the
  // MEM_TIMEOUT-th waiting cycle.
  localparam logic [TMO_W-1:0] LIMIT  = TMO_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
  localparam logic             ENABLE = (MEM_TIMEOUT > 0);

  logic [TMO_W-1:0] r_count;

  // Wait counter: cleared on request, otherwise counts stalled cycles and saturates
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + TMO_W'(1);
    end
  end

  assign o_expired = ENABLE && i_inc && (r_count == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS controller for a datapath with a single shared memory port.
// Sequences fetch/decode/execute/memory/writeback one instruction at a time,
// with a mem_ready handshake and an optional memory wait timeout.
//
// state      | meaning
// S_IDLE     | out of reset, all strobes low
// S_FETCH    | read instruction at PC, PC+4 -> PC on mem_ready
// S_DECODE   | branch target -> ALUOut, latch and dispatch opcode
// S_EXEC_R   | R-type ALU operation
// S_WB_R     | write ALUOut to rd
// S_EXEC_I   | ADDI/ORI/ANDI ALU operation
// S_WB_I     | write ALUOut to rt
// S_MEM_ADDR | compute load/store address
// S_MEM_RD   | data read, wait for mem_ready
// S_WB_MEM   | write MDR to rt
// S_MEM_WR   | data write, wait for mem_ready
// S_BR_EQ    | compare, load PC from ALUOut if equal
// S_BR_NE    | compare, load PC from ALUOut if not equal
// S_JUMP     | load PC with jump target
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TMO_W       = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_op,
  input  logic       i_mem_ready,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_pc_write_cond_eq,
  output logic       o_pc_write_cond_ne,
  output logic [1:0] o_pc_source,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_op,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_instr_done,
  output logic       o_illegal_op,
  output logic       o_mem_err,
  output logic [3:0] o_state
);

  state_t     r_state;
  logic [5:0] r_op;
  logic       r_illegal_op;
  logic       r_mem_err;

  logic       w_in_wait;
  logic       w_inc;
  logic       w_clr;
  logic       w_expired;

  // The counter only runs while an access is stalled; any other cycle
  // (including completion and abort) leaves it at zero for the next access.
  assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_inc     = w_in_wait && !i_mem_ready;
  assign w_clr     = !w_inc || w_expired;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMO_W       (TMO_W)
  ) u_mem_wait_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clr     (w_clr),
    .i_inc     (w_inc),
    .o_expired (w_expired)
  );

  // State sequencing, opcode latch and sticky error flags
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_illegal_op <= 1'b0;
      r_mem_err    <= 1'b0;
    end else begin
      if (w_expired) begin
        r_mem_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          // An expired fetch retries from FETCH with the PC untouched
          if (i_mem_ready) begin
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_op <= i_op;
          case (i_op)
            R_TYPE:          r_state <= S_EXEC_R;
            ADDI, ORI, ANDI: r_state <= S_EXEC_I;
            LW, SW:          r_state <= S_MEM_ADDR;
            BEQ:             r_state <= S_BR_EQ;
            BNE:             r_state <= S_BR_NE;
            J:               r_state <= S_JUMP;
            default: begin
              r_state      <= S_FETCH;
              r_illegal_op <= 1'b1;
            end
          endcase
        end
        S_EXEC_R: r_state <= S_WB_R;
        S_EXEC_I: r_state <= S_WB_I;
        S_MEM_ADDR: begin
          if (r_op == SW) begin
            r_state <= S_MEM_WR;
          end else begin
            r_state <= S_MEM_RD;
          end
        end
        S_MEM_RD: begin
          if (i_mem_ready) begin
            r_state <= S_WB_MEM;
          end else if (w_expired) begin
            r_state <= S_FETCH;
          end
        end
        S_MEM_WR: begin
          if (i_mem_ready || w_expired) begin
            r_state <= S_FETCH;
          end
        end
        S_WB_R, S_WB_I, S_WB_MEM, S_BR_EQ, S_BR_NE, S_JUMP: r_state <= S_FETCH;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the state register; only the completion strobes look at mem_ready
  always_comb begin
    o_iord             = 1'b0;
    o_mem_read         = 1'b0;
    o_mem_write        = 1'b0;
    o_ir_write         = 1'b0;
    o_pc_write         = 1'b0;
    o_pc_write_cond_eq = 1'b0;
    o_pc_write_cond_ne = 1'b0;
    o_pc_source        = PCSRC_ALU;
    o_alu_src_a        = 1'b0;
    o_alu_src_b        = SRCB_REG;
    o_alu_op           = 3'b000;
    o_reg_dst          = 1'b0;
    o_mem_to_reg       = 1'b0;
    o_reg_write        = 1'b0;
    o_instr_done       = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        o_alu_op    = ALU_ADD;
        o_pc_source = PCSRC_ALU;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_alu_src_b  = SRCB_IMM_SH2;
        o_alu_op     = ALU_ADD;
        // An unsupported opcode retires here as a NOP
        o_instr_done = !op_supported(i_op);
      end
      S_EXEC_R: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_REG;
        o_alu_op    = ALU_RTYPE;
      end
      S_WB_R: begin
        o_reg_dst    = 1'b1;
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
      end
      S_EXEC_I: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
        o_alu_op    = imm_alu_op(r_op);
      end
      S_WB_I: begin
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
        o_alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        o_iord     = 1'b1;
        o_mem_read = 1'b1;
      end
      S_WB_MEM: begin
        o_mem_to_reg = 1'b1;
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
      end
      S_MEM_WR: begin
        o_iord       = 1'b1;
        o_mem_write  = 1'b1;
        o_instr_done = i_mem_ready;
      end
      S_BR_EQ: begin
        o_alu_src_a        = 1'b1;
        o_alu_src_b        = SRCB_REG;
        o_alu_op           = ALU_SUB;
        o_pc_source        = PCSRC_ALUOUT;
        o_pc_write_cond_eq = 1'b1;
        o_instr_done       = 1'b1;
      end
      S_BR_NE: begin
        o_alu_src_a        = 1'b1;
        o_alu_src_b        = SRCB_REG;
        o_alu_op           = ALU_SUB;
        o_pc_source        = PCSRC_ALUOUT;
        o_pc_write_cond_ne = 1'b1;
        o_instr_done       = 1'b1;
      end
      S_JUMP: begin
        o_pc_source  = PCSRC_JUMP;
        o_pc_write   = 1'b1;
        o_instr_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_illegal_op = r_illegal_op;
  assign o_mem_err    = r_mem_err;
  assign o_state      = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle controller: one instance waits forever
// on memory, a second one gives up after five stalled cycles.
module tb_multicycle_control_fsm;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       ready;

  int n_cmp = 0;
  int n_err = 0;

  logic       a_iord, a_mr, a_mw, a_irw, a_pcw, a_ceq, a_cne, a_asa, a_rd, a_m2r, a_rw, a_done, a_ill, a_merr;
  logic [1:0] a_pcs, a_asb;
  logic [2:0] a_aop;
  logic [3:0] a_state;
  logic       b_iord, b_mr, b_mw, b_irw, b_pcw, b_ceq, b_cne, b_asa, b_rd, b_m2r, b_rw, b_done, b_ill, b_merr;
  logic [1:0] b_pcs, b_asb;
  logic [2:0] b_aop;
  logic [3:0] b_state;

  logic [18:0] a_ctl, b_ctl;
  assign a_ctl = {a_iord, a_mr, a_mw, a_irw, a_pcw, a_ceq, a_cne, a_pcs, a_asa, a_asb, a_aop, a_rd, a_m2r, a_rw, a_done};
  assign b_ctl = {b_iord, b_mr, b_mw, b_irw, b_pcw, b_ceq, b_cne, b_pcs, b_asa, b_asb, b_aop, b_rd, b_m2r, b_rw, b_done};

  multicycle_control_fsm #(.MEM_TIMEOUT(0), .TMO_W(8)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_op(op), .i_mem_ready(ready),
    .o_iord(a_iord), .o_mem_read(a_mr), .o_mem_write(a_mw), .o_ir_write(a_irw),
    .o_pc_write(a_pcw), .o_pc_write_cond_eq(a_ceq), .o_pc_write_cond_ne(a_cne),
    .o_pc_source(a_pcs), .o_alu_src_a(a_asa), .o_alu_src_b(a_asb), .o_alu_op(a_aop),
    .o_reg_dst(a_rd), .o_mem_to_reg(a_m2r), .o_reg_write(a_rw), .o_instr_done(a_done),
    .o_illegal_op(a_ill), .o_mem_err(a_merr), .o_state(a_state)
  );

  multicycle_control_fsm #(.MEM_TIMEOUT(5), .TMO_W(8)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_op(op), .i_mem_ready(ready),
    .o_iord(b_iord), .o_mem_read(b_mr), .o_mem_write(b_mw), .o_ir_write(b_irw),
    .o_pc_write(b_pcw), .o_pc_write_cond_eq(b_ceq), .o_pc_write_cond_ne(b_cne),
    .o_pc_source(b_pcs), .o_alu_src_a(b_asa), .o_alu_src_b(b_asb), .o_alu_op(b_aop),
    .o_reg_dst(b_rd), .o_mem_to_reg(b_m2r), .o_reg_write(b_rw), .o_instr_done(b_done),
    .o_illegal_op(b_ill), .o_mem_err(b_merr), .o_state(b_state)
  );

  always #5 clk = ~clk;

  // Packs the expected control word in the same field order as a_ctl/b_ctl
  function automatic logic [18:0] ctl(
    input logic iord, input logic mr, input logic mw, input logic irw, input logic pcw,
    input logic ceq, input logic cne, input logic [1:0] pcs, input logic asa,
    input logic [1:0] asb, input logic [2:0] aop, input logic rd, input logic m2r,
    input logic rw, input logic done);
    return {iord, mr, mw, irw, pcw, ceq, cne, pcs, asa, asb, aop, rd, m2r, rw, done};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check state and control word of one instance, then advance one cycle
  task automatic cyc(input bit use_b, input string tag, input logic [3:0] st, input logic [18:0] c);
    #1;
    check_eq({tag, ".state"}, use_b ? 32'(b_state) : 32'(a_state), 32'(st));
    check_eq({tag, ".ctl"},   use_b ? 32'(b_ctl)   : 32'(a_ctl),   32'(c));
    step();
  endtask

  logic [18:0] C_FETCH_W, C_FETCH_R, C_DEC, C_DEC_ILL, C_EXEC_R, C_WB_R, C_EXEC_ORI, C_WB_I;
  logic [18:0] C_MADDR, C_MRD, C_WB_MEM, C_MWR_W, C_MWR_R, C_BR_EQ, C_BR_NE, C_JUMP;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                  iord mr mw irw pcw ceq cne pcs    asa asb    aop     rd m2r rw done
    C_FETCH_W  = ctl(0,   1, 0, 0,  0,  0,  0,  2'b00, 0,  2'b01, 3'b100, 0, 0,  0, 0);
    C_FETCH_R  = ctl(0,   1, 0, 1,  1,  0,  0,  2'b00, 0,  2'b01, 3'b100, 0, 0,  0, 0);
    C_DEC      = ctl(0,   0, 0, 0,  0,  0,  0,  2'b00, 0,  2'b11, 3'b100, 0, 0,  0, 0);
    C_DEC_ILL  = ctl(0,   0, 0, 0,  0,  0,  0,  2'b00, 0,  2'b11, 3'b100, 0, 0,  0, 1);
    C_EXEC_R   = ctl(0,   0, 0, 0,  0,  0,  0,  2'b00, 1,  2'b00, 3'b111, 0, 0,  0, 0);
    C_WB_R     = ctl(0,   0, 0, 0,  0,  0,  0,  2'b00, 0,  2'b00, 3'b000, 1, 0,  1, 1);
    C_EXEC_ORI = ctl(0,   0, 0, 0,  0,  0,  0,  2'b00, 1,  2'b10, 3'b101, 0, 0,  0, 0);
    C_WB_I     = ctl(0,   0, 0, 0,  0,  0,  0,  2'b00, 0,  2'b00, 3'b000, 0, 0,  1, 1);
    C_MADDR    = ctl(0,   0, 0, 0,  0,  0,  0,  2'b00, 1,  2'b10, 3'b100, 0, 0,  0, 0);
    C_MRD      = ctl(1,   1, 0, 0,  0,  0,  0,  2'b00, 0,  2'b00, 3'b000, 0, 0,  0, 0);
    C_WB_MEM   = ctl(0,   0, 0, 0,  0,  0,  0,  2'b00, 0,  2'b00, 3'b000, 0, 1,  1, 1);
    C_MWR_W    = ctl(1,   0, 1, 0,  0,  0,  0,  2'b00, 0,  2'b00, 3'b000, 0, 0,  0, 0);
    C_MWR_R    = ctl(1,   0, 1, 0,  0,  0,  0,  2'b00, 0,  2'b00, 3'b000, 0, 0,  0, 1);
    C_BR_EQ    = ctl(0,   0, 0, 0,  0,  1,  0,  2'b01, 1,  2'b00, 3'b001, 0, 0,  0, 1);
    C_BR_NE    = ctl(0,   0, 0, 0,  0,  0,  1,  2'b01, 1,  2'b00, 3'b001, 0, 0,  0, 1);
    C_JUMP     = ctl(0,   0, 0, 0,  1,  0,  0,  2'b10, 0,  2'b00, 3'b000, 0, 0,  0, 1);

    reset = 1'b1;
    op    = 6'h00;
    ready = 1'b1;

    // Held in reset: everything low
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst.state", 32'(a_state), 32'(S_IDLE));
      check_eq("rst.ctl", 32'(a_ctl), 32'h0);
      check_eq("rst.flags", {30'd0, a_ill, a_merr}, 32'h0);
    end
    reset = 1'b0;

    // R-type, 4 cycles after IDLE
    cyc(0, "r.idle", S_IDLE, 19'd0);
    cyc(0, "r.fetch", S_FETCH, C_FETCH_R);
    cyc(0, "r.decode", S_DECODE, C_DEC);
    cyc(0, "r.exec", S_EXEC_R, C_EXEC_R);
    cyc(0, "r.wb", S_WB_R, C_WB_R);

    // LW with three stalled read cycles; OP changed after DECODE must not turn it into a store
    op = LW;
    cyc(0, "lw.fetch", S_FETCH, C_FETCH_R);
    cyc(0, "lw.decode", S_DECODE, C_DEC);
    op = SW;
    cyc(0, "lw.addr", S_MEM_ADDR, C_MADDR);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, "lw.wait", S_MEM_RD, C_MRD);
    ready = 1'b1;
    cyc(0, "lw.rd", S_MEM_RD, C_MRD);
    cyc(0, "lw.wb", S_WB_MEM, C_WB_MEM);

    // SW, 4 cycles
    cyc(0, "sw.fetch", S_FETCH, C_FETCH_R);
    cyc(0, "sw.decode", S_DECODE, C_DEC);
    cyc(0, "sw.addr", S_MEM_ADDR, C_MADDR);
    cyc(0, "sw.wr", S_MEM_WR, C_MWR_R);

    // ORI: ALUOp comes from the latched opcode even if OP moves on
    op = ORI;
    cyc(0, "ori.fetch", S_FETCH, C_FETCH_R);
    cyc(0, "ori.decode", S_DECODE, C_DEC);
    op = ADDI;
    cyc(0, "ori.exec", S_EXEC_I, C_EXEC_ORI);
    cyc(0, "ori.wb", S_WB_I, C_WB_I);

    // BNE then J, 3 cycles each
    op = BNE;
    cyc(0, "bne.fetch", S_FETCH, C_FETCH_R);
    cyc(0, "bne.decode", S_DECODE, C_DEC);
    cyc(0, "bne.br", S_BR_NE, C_BR_NE);
    op = J;
    cyc(0, "j.fetch", S_FETCH, C_FETCH_R);
    cyc(0, "j.decode", S_DECODE, C_DEC);
    cyc(0, "j.jump", S_JUMP, C_JUMP);

    // Illegal opcode retires as a NOP from DECODE; flag is sticky
    op = 6'h3F;
    cyc(0, "ill.fetch", S_FETCH, C_FETCH_R);
    check_eq("ill.flag_pre", 32'(a_ill), 32'd0);
    cyc(0, "ill.decode", S_DECODE, C_DEC_ILL);
    check_eq("ill.flag_set", 32'(a_ill), 32'd1);
    op = BEQ;
    cyc(0, "beq.fetch", S_FETCH, C_FETCH_R);
    cyc(0, "beq.decode", S_DECODE, C_DEC);
    cyc(0, "beq.br", S_BR_EQ, C_BR_EQ);
    check_eq("ill.flag_sticky", 32'(a_ill), 32'd1);
    check_eq("a.mem_err", 32'(a_merr), 32'd0);

    // Reset in the middle of a stalled write drops MemWrite at once
    op = SW;
    cyc(0, "swr.fetch", S_FETCH, C_FETCH_R);
    cyc(0, "swr.decode", S_DECODE, C_DEC);
    cyc(0, "swr.addr", S_MEM_ADDR, C_MADDR);
    ready = 1'b0;
    #1;
    check_eq("swr.wr_state", 32'(a_state), 32'(S_MEM_WR));
    check_eq("swr.wr_pending", 32'(a_mw), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("swr.mw_drop", 32'(a_mw), 32'd0);
    check_eq("swr.state_idle", 32'(a_state), 32'(S_IDLE));
    check_eq("swr.ill_clr", 32'(a_ill), 32'd0);
    step();
    step();

    // Timeout instance: mem_ready arrives on the 5th stalled fetch cycle and wins
    reset = 1'b0;
    ready = 1'b0;
    cyc(1, "t.idle", S_IDLE, 19'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("t.merr_wait", 32'(b_merr), 32'd0);
      cyc(1, "t.wait", S_FETCH, C_FETCH_W);
    end
    ready = 1'b1;
    op = J;
    cyc(1, "t.rdy5", S_FETCH, C_FETCH_R);
    check_eq("t.merr_ok", 32'(b_merr), 32'd0);
    cyc(1, "t.decode", S_DECODE, C_DEC);
    cyc(1, "t.jump", S_JUMP, C_JUMP);

    // No response for five fetch cycles: abort, flag, retry with a fresh count
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("to.merr_pre", 32'(b_merr), 32'd0);
      cyc(1, "to.wait", S_FETCH, C_FETCH_W);
    end
    check_eq("to.merr_set", 32'(b_merr), 32'd1);
    for (int i = 0; i < 4; i++) cyc(1, "to.retry", S_FETCH, C_FETCH_W);
    ready = 1'b1;
    cyc(1, "to.retry_rdy", S_FETCH, C_FETCH_R);
    cyc(1, "to.decode", S_DECODE, C_DEC);
    check_eq("to.merr_sticky", 32'(b_merr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
